// File: rtl/rx_if.sv
// Byte-delivery handshake between the serial receiver and its consumer.
interface rx_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       parity_err;
  logic       frame_err;

  // Receiver side drives the byte and status; consumer drives ready.
  modport master (
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  parity_err,
    input  frame_err,
    output data_ready
  );
endinterface

// File: rtl/rx_module.sv
// Serial receiver: start(0), 8 data bits LSB-first, parity, stop(1) on an idle-high line.
// Each received byte is offered on a valid/ready interface with parity and framing
// status; a frame completing while the previous byte is still unaccepted is dropped
// and flagged by the sticky overrun output.
module rx_module #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic rx_i,
  rx_if.master bus,
  output logic overrun_o,
  output logic busy_o
);

  localparam int unsigned Half = CLKS_PER_BIT / 2;
  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntHalf = CntW'(Half);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic            ParOdd  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rs;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            frame_perr_q;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            perr_q;
  logic            ferr_q;
  logic            overrun_q;
  logic            busy_q;

  // Input synchronizer; preset to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= SYNC_STAGES'({sync_q, rx_i});
    end
  end

  assign rs = sync_q[SYNC_STAGES-1];

  // Receive FSM, bit timing, shift register and output handshake.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      frame_perr_q <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // An accepting handshake; a delivery below in the same cycle overrides valid_q.
      if (valid_q && bus.data_ready) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          // Detection cycle is counter 0 of the start bit.
          if (!rs) begin
            busy_q    <= 1'b1;
            bit_idx_q <= '0;
            if (CLKS_PER_BIT == 1) begin
              // Single-cycle bits: the detection cycle is also the mid-bit check.
              state_q <= StData;
              cnt_q   <= '0;
            end else begin
              state_q <= StStart;
              cnt_q   <= CntOne;
            end
          end
        end

        StStart: begin
          if (cnt_q == CntHalf && rs) begin
            // Too short to be a start bit.
            state_q <= StIdle;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= StData;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StData: begin
          if (cnt_q == CntHalf) begin
            shift_q <= {rs, shift_q[7:1]};
          end
          if (cnt_q == CntLast) begin
            cnt_q     <= '0;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= StParity;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StParity: begin
          if (cnt_q == CntHalf) begin
            frame_perr_q <= ^shift_q ^ rs ^ ParOdd;
          end
          if (cnt_q == CntLast) begin
            state_q <= StStop;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StStop: begin
          if (cnt_q == CntHalf) begin
            // Finish at mid-stop so a following start bit is not missed.
            cnt_q <= '0;
            if (rs) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              state_q <= StBreak;
            end
            if (!valid_q || bus.data_ready) begin
              data_q  <= shift_q;
              perr_q  <= frame_perr_q;
              ferr_q  <= !rs;
              valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StBreak: begin
          // Line held low past the stop bit: ignore it until it returns high.
          if (rs) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign overrun_o      = overrun_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_rx_module.sv
// Bench for rx_module: two instances (1 and 16 clocks per bit, odd and even parity)
// driven with directed and random frames, checked against a frame-level model.
module tb_rx_module;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] rx_l;
  logic [1:0] ready_l;
  logic [1:0] ovr_w;
  logic [1:0] busy_w;

  always #5 clk = ~clk;

  rx_if bus0 ();
  rx_if bus1 ();

  assign bus0.data_ready = ready_l[0];
  assign bus1.data_ready = ready_l[1];

  rx_module #(
    .CLKS_PER_BIT(1),
    .PARITY_ODD  (1),
    .SYNC_STAGES (2)
  ) u_dut0 (
    .clk_i    (clk),
    .reset_i  (reset),
    .rx_i     (rx_l[0]),
    .bus      (bus0),
    .overrun_o(ovr_w[0]),
    .busy_o   (busy_w[0])
  );

  rx_module #(
    .CLKS_PER_BIT(16),
    .PARITY_ODD  (0),
    .SYNC_STAGES (3)
  ) u_dut1 (
    .clk_i    (clk),
    .reset_i  (reset),
    .rx_i     (rx_l[1]),
    .bus      (bus1),
    .overrun_o(ovr_w[1]),
    .busy_o   (busy_w[1])
  );

  logic [7:0] obs_data [2];
  logic [1:0] obs_valid;
  logic [1:0] obs_perr;
  logic [1:0] obs_ferr;

  assign obs_data[0]  = bus0.data_out;
  assign obs_data[1]  = bus1.data_out;
  assign obs_valid[0] = bus0.data_valid;
  assign obs_valid[1] = bus1.data_valid;
  assign obs_perr[0]  = bus0.parity_err;
  assign obs_perr[1]  = bus1.parity_err;
  assign obs_ferr[0]  = bus0.frame_err;
  assign obs_ferr[1]  = bus1.frame_err;

  int n_vec = 0;
  int n_err = 0;

  // Frame-level reference state per instance.
  bit       exp_valid [2];
  bit [7:0] exp_data  [2];
  bit       exp_perr  [2];
  bit       exp_ferr  [2];
  bit       exp_ovr   [2];

  function automatic int cpb(input int s);
    return (s == 0) ? 1 : 16;
  endfunction

  function automatic int sync_n(input int s);
    return (s == 0) ? 2 : 3;
  endfunction

  function automatic bit odd(input int s);
    return (s == 0);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input int s, input string tag);
    check_eq($sformatf("%s u%0d valid", tag, s), 32'(obs_valid[s]), 32'(exp_valid[s]));
    check_eq($sformatf("%s u%0d data", tag, s), 32'(obs_data[s]), 32'(exp_data[s]));
    check_eq($sformatf("%s u%0d parity_err", tag, s), 32'(obs_perr[s]), 32'(exp_perr[s]));
    check_eq($sformatf("%s u%0d frame_err", tag, s), 32'(obs_ferr[s]), 32'(exp_ferr[s]));
    check_eq($sformatf("%s u%0d overrun", tag, s), 32'(ovr_w[s]), 32'(exp_ovr[s]));
    check_eq($sformatf("%s u%0d busy", tag, s), 32'(busy_w[s]), 32'd0);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      exp_valid[s] = 1'b0;
      exp_data[s]  = 8'h00;
      exp_perr[s]  = 1'b0;
      exp_ferr[s]  = 1'b0;
      exp_ovr[s]   = 1'b0;
    end
  endtask

  // One completed frame; acc means the consumer was ready at the moment of delivery.
  task automatic model_frame(input int s, input logic [7:0] d, input logic pbit,
                             input logic sbit, input bit acc);
    int ones;
    bit perr;
    ones = $countones(d) + int'(pbit);
    perr = odd(s) ? (ones % 2 == 0) : (ones % 2 != 0);
    if (!exp_valid[s] || acc) begin
      if (exp_valid[s]) exp_ovr[s] = 1'b0;
      exp_valid[s] = 1'b1;
      exp_data[s]  = d;
      exp_perr[s]  = perr;
      exp_ferr[s]  = !sbit;
    end else begin
      exp_ovr[s] = 1'b1;
    end
  endtask

  task automatic accept(input int s, input string tag);
    ready_l[s] = 1'b1;
    @(negedge clk);
    ready_l[s] = 1'b0;
    if (exp_valid[s]) begin
      exp_valid[s] = 1'b0;
      exp_ovr[s]   = 1'b0;
    end
    check_outputs(s, tag);
  endtask

  // Drive one frame; a quiet frame is followed by enough idle line to check the outputs.
  task automatic send_frame(input int s, input logic [7:0] d, input logic pbit,
                            input logic sbit, input int brk, input int gap, input bit quiet,
                            input bit sim_acc, input string tag);
    int c, lat_exp, lat, hold;
    bit was;
    c       = cpb(s);
    lat_exp = sync_n(s) + c / 2 + 1;
    was     = exp_valid[s];
    lat     = -1;
    rx_l[s] = 1'b0;
    repeat (c) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_l[s] = d[i];
      repeat (c) @(negedge clk);
    end
    rx_l[s] = pbit;
    repeat (c) @(negedge clk);
    rx_l[s] = sbit;
    hold    = sbit ? c : c + brk;
    for (int n = 1; n <= hold + gap; n++) begin
      @(negedge clk);
      if (lat < 0 && obs_valid[s]) lat = n;
      if (n == hold) rx_l[s] = 1'b1;
      if (sim_acc) begin
        if (n == lat_exp - 1) ready_l[s] = 1'b1;
        else if (n == lat_exp) ready_l[s] = 1'b0;
      end
    end
    model_frame(s, d, pbit, sbit, sim_acc);
    if (quiet) begin
      if (!was) check_eq($sformatf("%s u%0d latency", tag, s), 32'(lat), 32'(lat_exp));
      check_outputs(s, tag);
    end
  endtask

  function automatic logic good_par(input int s, input logic [7:0] d);
    return (^d) ^ odd(s);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int s, brk, gap;
    bit quiet, sim_acc;
    logic [7:0] d;
    logic pbit, sbit;

    reset   = 1'b1;
    rx_l    = 2'b11;
    ready_l = 2'b00;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outputs(0, "reset");
    check_outputs(1, "reset");

    // Single-cycle bits, byte held until accepted.
    send_frame(0, 8'hA5, good_par(0, 8'hA5), 1'b1, 0, 12, 1'b1, 1'b0, "a5");
    repeat (5) @(negedge clk);
    check_outputs(0, "a5 held");
    accept(0, "a5 accept");

    // Parity good then bad at 16 clocks per bit.
    send_frame(1, 8'h3C, 1'b0, 1'b1, 0, 12, 1'b1, 1'b0, "3c par0");
    accept(1, "3c accept");
    send_frame(1, 8'h3C, 1'b1, 1'b1, 0, 12, 1'b1, 1'b0, "3c par1");
    accept(1, "3c accept2");

    // Short low pulse is rejected.
    rx_l[1] = 1'b0;
    repeat (3) @(negedge clk);
    rx_l[1] = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("glitch busy", 32'(busy_w[1]), 32'd1);
    repeat (20) @(negedge clk);
    check_outputs(1, "glitch");

    // Stop bit low with a long break, then a normal frame.
    send_frame(1, 8'hC3, good_par(1, 8'hC3), 1'b0, 40, 12, 1'b1, 1'b0, "break");
    accept(1, "break accept");
    send_frame(1, 8'h55, good_par(1, 8'h55), 1'b1, 0, 12, 1'b1, 1'b0, "55");

    // Back-to-back frames with no consumer: second one is dropped.
    send_frame(0, 8'h11, good_par(0, 8'h11), 1'b1, 0, 0, 1'b0, 1'b0, "11");
    send_frame(0, 8'h22, good_par(0, 8'h22), 1'b1, 0, 12, 1'b1, 1'b0, "22 overrun");
    accept(0, "overrun clear");

    // Reset during data bit 4 aborts the frame.
    rx_l[1] = 1'b0;
    repeat (16 + 4 * 16 + 8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    rx_l[1] = 1'b1;
    model_reset();
    check_outputs(0, "mid reset");
    check_outputs(1, "mid reset");
    repeat (10) @(negedge clk);
    send_frame(1, 8'h81, good_par(1, 8'h81), 1'b1, 0, 12, 1'b1, 1'b0, "81");

    // Delivery in the same cycle as an accepting handshake.
    send_frame(1, 8'h5A, good_par(1, 8'h5A), 1'b1, 0, 12, 1'b1, 1'b1, "sim acc");

    for (int it = 0; it < 60; it++) begin
      s       = int'($urandom_range(1, 0));
      d       = 8'($urandom);
      pbit    = good_par(s, d) ^ ($urandom_range(3, 0) == 0);
      sbit    = ($urandom_range(5, 0) != 0);
      brk     = sbit ? 0 : int'($urandom_range(30, 0));
      quiet   = ($urandom_range(2, 0) != 0);
      sim_acc = quiet && ($urandom_range(3, 0) == 0);
      if (quiet) gap = 12;
      else gap = sbit ? int'($urandom_range(2, 0)) : 2 + int'($urandom_range(1, 0));
      send_frame(s, d, pbit, sbit, brk, gap, quiet, sim_acc, $sformatf("rnd%0d", it));
      if (quiet && $urandom_range(1, 0) == 1) accept(s, $sformatf("rnd%0d acc", it));
    end

    // Flush both instances and compare final state.
    repeat (40) @(negedge clk);
    check_outputs(0, "final");
    check_outputs(1, "final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
